terrain_carver: RTL and testbench
=================================

TERRAIN_CARVER -- requirements
Module: terrain_carver

Interface
REQ-001 Parameter: NCOLS, 640, number of terrain columns; valid column addresses 0..NCOLS-1.
REQ-002 Parameter: NROWS, 512, bits per column word; bit index = screen Y.
REQ-003 Port: clk  in  1  system clock; all logic on posedge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: req  in  1  start-carve strobe; sampled only in IDLE.
REQ-006 Port: cx  in  10  crater centre X (column), unsigned.
REQ-007 Port: cy  in  10  crater centre Y (bit index), unsigned.
REQ-008 Port: radius  in  5  crater radius, 0..31.
REQ-009 Port: busy  out  1  high from the cycle after an accepted req until done.
REQ-010 Port: done  out  1  one-cycle pulse when the carve completes.
REQ-011 Port: mem_addr  out  10  terrain column address for read and write.
REQ-012 Port: mem_rd  out  1  read strobe; mem_rdata is valid exactly 1 cycle later.
REQ-013 Port: mem_rdata  in  NROWS  column word returned by terrain RAM.
REQ-014 Port: mem_we  out  1  write strobe for mem_wdata at mem_addr.
REQ-015 Port: mem_wdata  out  NROWS  modified column word.

Function
REQ-016 The block SHALL clear every terrain bit (x,y) with (x-cx)^2+(y-cy)^2 <= radius^2, 0<=x<NCOLS, 0<=y<NROWS, and SHALL leave every other bit unchanged.
REQ-017 In IDLE, req=1 SHALL latch cx, cy and radius, and SHALL enter SETUP; req SHALL be ignored in all other states.
REQ-018 SETUP SHALL compute x_lo=max(cx-radius,0) and x_hi=min(cx+radius,NCOLS-1) using signed 12-bit arithmetic; if x_lo>x_hi (cx beyond the last column by more than radius), the FSM SHALL go to DONE without any memory access.
REQ-019 For each column x from x_lo to x_hi ascending, the FSM SHALL run HCALC -> READ -> WAIT -> WRITE, then advance to NEXT.
REQ-020 HCALC SHALL set dx=x-cx (signed), load h=radius, and decrement h one step per cycle while h*h+dx*dx > radius*radius; the squares and sum SHALL be 12 bits unsigned with no overflow (max 1922).
REQ-021 HCALC SHALL always terminate with h>=0, because |dx|<=radius.
REQ-022 READ SHALL assert mem_rd=1 for one cycle with mem_addr=x; WAIT SHALL capture mem_rdata.
REQ-023 WRITE SHALL assert mem_we=1 for one cycle with mem_addr=x and mem_wdata=captured word AND NOT mask, where mask bit y=1 iff cy-h<=y<=cy+h, clipped to 0..NROWS-1.
REQ-024 A span lying wholly outside 0..NROWS-1 (cy-h>=NROWS) SHALL produce mask=0, and the word SHALL still be written back unchanged.
REQ-025 NEXT SHALL go to HCALC for x+1 if x<x_hi, and otherwise to DONE.
REQ-026 DONE SHALL assert done=1 for exactly one cycle, deassert busy, and return to IDLE; a req in the DONE cycle SHALL be ignored.
REQ-027 mem_rd and mem_we SHALL never both be high, and both SHALL be low outside READ and WRITE respectively.
REQ-028 radius=0 SHALL carve only bit cy of column cx, provided cx<NCOLS.
REQ-029 Worst-case latency SHALL be 2+ (x_hi-x_lo+1)*(radius+5) cycles from req to done.

Reset
REQ-030 When reset=1, the FSM SHALL enter IDLE, and busy, done, mem_rd and mem_we SHALL be 0; mem_addr and mem_wdata SHALL be 0.
REQ-031 Reset mid-carve SHALL abort without completing the current write; columns already written SHALL keep their carved contents, and no done pulse SHALL be issued.

Verification
REQ-032 All-ones RAM, cx=100, cy=200, radius=3 -> 7 writes, columns 97..103; cleared bits: col 97 {200}; col 98 and col 102 {198..202}; col 99 and col 101 {198..202}; col 100 {197..203}; col 103 {200}; one done pulse.
REQ-033 cx=2, cy=1, radius=5 -> columns 0..7 written, no address below 0; col 2 clears bits 0..6, with the low side clipped at bit 0.
REQ-034 cx=639, cy=511, radius=4 -> columns 635..639 only; col 639 clears bits 507..511.
REQ-035 cx=700, radius=31 -> no mem_rd or mem_we; done 2 cycles after req.
REQ-036 Second req pulsed during busy with different cx -> ignored; only the first crater is carved; a req asserted after done starts a new carve.
REQ-037 reset pulsed during the third column's WAIT for cx=100, radius=3 -> columns 97 and 98 modified, 99..103 untouched, busy=0, done never asserted.

Source files
------------

// File: rtl/terrain_carver.sv
// terrain_carver: clears a circular crater from a column-organised
// terrain bitmap held in an external single-port RAM.
module terrain_carver #(
  parameter int NCOLS = 640,
  parameter int NROWS = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [9:0]       cx,
  input  logic [9:0]       cy,
  input  logic [4:0]       radius,
  output logic             busy,
  output logic             done,
  output logic [9:0]       mem_addr,
  output logic             mem_rd,
  input  logic [NROWS-1:0] mem_rdata,
  output logic             mem_we,
  output logic [NROWS-1:0] mem_wdata
);

  typedef enum logic [2:0] {
    IDLE, SETUP, HCALC, READ, WAIT, WRITE, NEXT, DONE
  } state_t;

  localparam logic signed [11:0] XMAX = 12'(NCOLS - 1);

  state_t             state_q;
  logic [9:0]         cx_q, cy_q;
  logic [4:0]         r_q, h_q;
  logic signed [11:0] x_q, xhi_q;
  logic               busy_q, done_q, rd_q, we_q;
  logic [9:0]         addr_q;
  logic [NROWS-1:0]   wdata_q;

  logic signed [11:0] xlo_s, xhi_s, xlo_c, xhi_c;
  logic signed [11:0] dx_s, adx_s, lo_s, hi_s;
  logic [11:0]        dist2, r2;
  logic [NROWS-1:0]   mask;

  always_comb begin
    xlo_s = $signed({2'b0, cx_q}) - $signed({7'b0, r_q});
    xhi_s = $signed({2'b0, cx_q}) + $signed({7'b0, r_q});
    xlo_c = (xlo_s < 12'sd0) ? 12'sd0 : xlo_s;
    xhi_c = (xhi_s > XMAX) ? XMAX : xhi_s;
    dx_s  = x_q - $signed({2'b0, cx_q});
    adx_s = (dx_s < 12'sd0) ? -dx_s : dx_s;
    // |dx| <= radius, so both squares stay well inside 12 bits
    dist2 = {7'b0, h_q} * {7'b0, h_q}
          + $unsigned(adx_s) * $unsigned(adx_s);
    r2    = {7'b0, r_q} * {7'b0, r_q};
    lo_s  = $signed({2'b0, cy_q}) - $signed({7'b0, h_q});
    hi_s  = $signed({2'b0, cy_q}) + $signed({7'b0, h_q});
    for (int y = 0; y < NROWS; y++) begin
      mask[y] = ($signed(12'(y)) >= lo_s) &&
                ($signed(12'(y)) <= hi_s);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      r_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      xhi_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            cx_q    <= cx;
            cy_q    <= cy;
            r_q     <= radius;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (xlo_c > xhi_c) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            x_q     <= xlo_c;
            xhi_q   <= xhi_c;
            h_q     <= r_q;
            state_q <= HCALC;
          end
        end
        HCALC: begin
          if (dist2 > r2) begin
            h_q <= h_q - 5'd1;
          end else begin
            rd_q    <= 1'b1;
            addr_q  <= x_q[9:0];
            state_q <= READ;
          end
        end
        READ: begin
          rd_q    <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          wdata_q <= mem_rdata & ~mask;
          we_q    <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          we_q    <= 1'b0;
          state_q <= NEXT;
        end
        NEXT: begin
          if (x_q < xhi_q) begin
            x_q     <= x_q + 12'sd1;
            h_q     <= r_q;
            state_q <= HCALC;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd    = rd_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_terrain_carver.sv
// Directed bench for terrain_carver: table of craters checked against
// an independent circle model, plus busy/reset corner sequences.
module tb_terrain_carver;

  logic         clk = 1'b0;
  logic         reset, req;
  logic [9:0]   cx, cy;
  logic [4:0]   radius;
  logic         busy, done, mem_rd, mem_we;
  logic [9:0]   mem_addr;
  logic [511:0] mem_rdata, mem_wdata;
  logic [511:0] ram [640];

  int nchk = 0;
  int nfail = 0;
  int wcnt, rcnt, dcnt, amin, amax;
  int both = 0;
  int oob = 0;

  typedef struct {
    int cx, cy, r, nw, xlo, xhi, ccol, clo, chi, lat;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  terrain_carver #(.NCOLS(640), .NROWS(512)) dut (
    .clk(clk), .reset(reset), .req(req),
    .cx(cx), .cy(cy), .radius(radius),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always @(posedge clk) begin
    if (mem_rd && mem_addr < 10'd640) mem_rdata <= ram[mem_addr];
    if (mem_we && mem_addr < 10'd640) ram[mem_addr] <= mem_wdata;
  end

  always @(posedge clk) begin
    #2;
    if (mem_we) begin
      wcnt++;
      if (int'(mem_addr) < amin) amin = int'(mem_addr);
      if (int'(mem_addr) > amax) amax = int'(mem_addr);
    end
    if (mem_rd) rcnt++;
    if (done) dcnt++;
    if (mem_rd && mem_we) both++;
    if ((mem_rd || mem_we) && mem_addr >= 10'd640) oob++;
  end

  task automatic check(string nm, longint got, longint exp);
    nchk++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [511:0] model_col(int x, int c_x, int c_y, int r);
    logic [511:0] w = '1;
    for (int y = 0; y < 512; y++)
      if ((x - c_x) * (x - c_x) + (y - c_y) * (y - c_y) <= r * r)
        w[y] = 1'b0;
    return w;
  endfunction

  function automatic int ram_errs(int c_x, int c_y, int r, int lo, int hi);
    int e = 0;
    logic [511:0] w;
    for (int i = 0; i < 640; i++) begin
      w = (i >= lo && i <= hi) ? model_col(i, c_x, c_y, r) : '1;
      if (ram[i] !== w) e++;
    end
    return e;
  endfunction

  task automatic fill_ram();
    for (int i = 0; i < 640; i++) ram[i] = '1;
  endtask

  task automatic clr_counts();
    wcnt = 0; rcnt = 0; dcnt = 0; amin = 9999; amax = -1;
  endtask

  task automatic run(input int c_x, input int c_y, input int r,
                     output int lat);
    @(negedge clk);
    clr_counts();
    cx = 10'(c_x); cy = 10'(c_y); radius = 5'(r); req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    check("busy_after_req", longint'(busy), 1);
    while (!done && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int lat, nrd, n;
    logic [511:0] w;
    vecs[0] = '{100, 200, 3, 7, 97, 103, 100, 197, 203, 47};
    vecs[1] = '{2, 1, 5, 8, 0, 7, 2, 0, 6, 0};
    vecs[2] = '{639, 511, 4, 5, 635, 639, 639, 507, 511, 35};
    vecs[3] = '{700, 0, 31, 0, 1, 0, 639, 1, 0, 2};
    vecs[4] = '{10, 20, 0, 1, 10, 10, 10, 20, 20, 7};
    vecs[5] = '{50, 1000, 2, 5, 48, 52, 50, 1, 0, 33};
    vecs[6] = '{640, 5, 1, 1, 639, 639, 639, 5, 5, 8};

    reset = 1'b1; req = 1'b0; cx = '0; cy = '0; radius = '0;
    fill_ram();
    clr_counts();
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_rd", longint'(mem_rd), 0);
    check("rst_we", longint'(mem_we), 0);
    check("rst_addr", longint'(mem_addr), 0);
    check("rst_wdata_zero", longint'(mem_wdata == '0), 1);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      fill_ram();
      run(vecs[v].cx, vecs[v].cy, vecs[v].r, lat);
      check($sformatf("v%0d_writes", v), wcnt, vecs[v].nw);
      check($sformatf("v%0d_reads", v), rcnt, vecs[v].nw);
      check($sformatf("v%0d_done_pulses", v), dcnt, 1);
      check($sformatf("v%0d_busy_end", v), longint'(busy), 0);
      if (vecs[v].nw > 0) begin
        check($sformatf("v%0d_addr_lo", v), amin, vecs[v].xlo);
        check($sformatf("v%0d_addr_hi", v), amax, vecs[v].xhi);
      end
      if (vecs[v].lat > 0)
        check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      else
        check($sformatf("v%0d_latency_bound", v),
              longint'(lat <= 2 + vecs[v].nw * (vecs[v].r + 5)), 1);
      w = '1;
      for (int y = vecs[v].clo; y <= vecs[v].chi; y++) w[y] = 1'b0;
      check($sformatf("v%0d_col%0d_exact", v, vecs[v].ccol),
            longint'(ram[vecs[v].ccol] === w), 1);
      check($sformatf("v%0d_model_col_errs", v),
            ram_errs(vecs[v].cx, vecs[v].cy, vecs[v].r,
                     vecs[v].xlo, vecs[v].xhi), 0);
    end

    // second req while busy, held through the DONE cycle
    fill_ram();
    @(negedge clk);
    clr_counts();
    cx = 10'd100; cy = 10'd200; radius = 5'd3; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    cx = 10'd300; req = 1'b1;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("busy_req_timeout", 0, 1);
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_req_idle", longint'(busy), 0);
    check("busy_req_writes", wcnt, 7);
    check("busy_req_addr_hi", amax, 103);
    check("busy_req_done_pulses", dcnt, 1);
    check("busy_req_model", ram_errs(100, 200, 3, 97, 103), 0);

    fill_ram();
    run(300, 50, 2, lat);
    check("after_done_writes", wcnt, 5);
    check("after_done_model", ram_errs(300, 50, 2, 298, 302), 0);

    // reset during the third column's WAIT
    fill_ram();
    @(negedge clk);
    clr_counts();
    cx = 10'd100; cy = 10'd200; radius = 5'd3; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    nrd = 0; n = 0;
    while (nrd < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (mem_rd) nrd++;
    end
    if (nrd < 3) check("abort_read_timeout", nrd, 3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy", longint'(busy), 0);
    check("abort_done_pulses", dcnt, 0);
    check("abort_writes", wcnt, 2);
    check("abort_we", longint'(mem_we), 0);
    check("abort_addr", longint'(mem_addr), 0);
    check("abort_model", ram_errs(100, 200, 3, 97, 98), 0);

    check("rd_we_overlap", both, 0);
    check("addr_out_of_range", oob, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
